// File: rtl/rx_pkg.sv
// Shared definitions for the receive path: destination codes, the default
// slot EtherType and the header classifier used by rx_classifier.
package rx_pkg;

  typedef enum logic [1:0] {
    DEST_PASS = 2'd0,
    DEST_SLT1 = 2'd1,
    DEST_SLT2 = 2'd2
  } dest_e;

  typedef enum logic {
    ST_HDR  = 1'b0,
    ST_BODY = 1'b1
  } rx_state_e;

  localparam logic [15:0] MAGIC_DEFAULT = 16'h88B5;

  // Only the EtherType and the two slot-select bits of word 0 matter.
  function automatic dest_e classify(input logic [17:0] w, input logic [15:0] magic);
    if (w[15:0] != magic) return DEST_PASS;
    case (w[17:16])
      2'd1:    return DEST_SLT1;
      2'd2:    return DEST_SLT2;
      default: return DEST_PASS;
    endcase
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/rx_classifier_if.sv
// Valid/ready packet stream; W sets the data width (32 for packets, 2 for codes).
interface rx_classifier_if #(parameter int W = 32);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/rx_dest_fifo.sv
// Small destination-code FIFO: no bypass, push refused when full even if a
// pop happens in the same cycle, pop ignored when empty.
module rx_dest_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign valid   = (count != '0);
  assign do_push = push && !full;
  assign do_pop  = pop && valid;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rx_classifier.sv
// Classifies each incoming packet by its first word, forwards the packet with
// one cycle of latency and queues the destination code for the arbiter.
module rx_classifier
  import rx_pkg::*;
#(
  parameter logic [15:0] MAGIC      = MAGIC_DEFAULT,
  parameter int          DEST_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  rx_classifier_if.slave         mac_fifo,
  rx_classifier_if.master        rxif_fifo,
  rx_classifier_if.master        arb_fifo,
  output logic [15:0]            cnt_pass,
  output logic [15:0]            cnt_slt1,
  output logic [15:0]            cnt_slt2
);
  rx_state_e  state;
  dest_e      code;
  logic       can_take, accept, push, full;
  logic [1:0] fifo_dout;

  assign can_take = !rxif_fifo.tvalid || rxif_fifo.tready;
  // A header is held back while the code queue is full, so a code is never
  // queued without its packet being forwarded.
  assign mac_fifo.tready = rst && can_take && ((state == ST_BODY) || !full);
  assign accept = mac_fifo.tvalid && mac_fifo.tready;
  assign push   = accept && (state == ST_HDR);
  assign code   = classify(mac_fifo.tdata[17:0], MAGIC);

  rx_dest_fifo #(.WIDTH(2), .DEPTH(DEST_DEPTH)) u_dest_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (code),
    .pop   (arb_fifo.tready),
    .dout  (fifo_dout),
    .valid (arb_fifo.tvalid),
    .full  (full)
  );

  assign arb_fifo.tdata = fifo_dout;
  assign arb_fifo.tlast = 1'b0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_HDR;
    else if (accept) state <= mac_fifo.tlast ? ST_HDR : ST_BODY;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxif_fifo.tvalid <= 1'b0;
      rxif_fifo.tdata  <= '0;
      rxif_fifo.tlast  <= 1'b0;
    end else if (accept) begin
      rxif_fifo.tvalid <= 1'b1;
      rxif_fifo.tdata  <= mac_fifo.tdata;
      rxif_fifo.tlast  <= mac_fifo.tlast;
    end else if (rxif_fifo.tready) begin
      rxif_fifo.tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_pass <= '0;
      cnt_slt1 <= '0;
      cnt_slt2 <= '0;
    end else if (push) begin
      case (code)
        DEST_SLT1: cnt_slt1 <= sat_inc(cnt_slt1);
        DEST_SLT2: cnt_slt2 <= sat_inc(cnt_slt2);
        default:   cnt_pass <= sat_inc(cnt_pass);
      endcase
    end
  end

endmodule
